// File: rtl/add_core_pkg.sv
// add_core shared types and defaults.
// Count-width macro sizes FIFO occupancy counters.
`define ADD_CORE_CNT_W(d) ($clog2(d) + 1)

package add_core_pkg_hdl;

  localparam int DATA_W_DEF = 8;
  localparam int FIFO_D_DEF = 4;
  localparam int TAG_W_DEF  = 4;
  localparam int CC_W       = 16;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic                  carry;
    logic [DATA_W_DEF-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/add_core_fifo.sv
// Result FIFO: wrap-bit pointers, occupancy count,
// head data forced to zero while empty.
module add_core_fifo
  import add_core_pkg_hdl::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = FIFO_D_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head,
  output logic                              empty,
  output logic [`ADD_CORE_CNT_W(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop may both happen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Upstream credit logic must keep a push off a full FIFO.
  push_never_full: assert property (
    @(posedge clock) disable iff (!reset) !(push && full)
  );

endmodule

// File: rtl/add_core.sv
// Two-stage pipelined adder with credit-gated
// result FIFO and saturating carry counter.
module add_core
  import add_core_pkg_hdl::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_D_DEF,
  parameter int TAG_WIDTH  = TAG_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_carry,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [CC_W-1:0]       carry_count
);

  localparam int CW = `ADD_CORE_CNT_W(FIFO_DEPTH);
  localparam int RW = TAG_WIDTH + 1 + DATA_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [DATA_WIDTH:0]   s1_sum;
  logic                  accept;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credits;
  logic                  fifo_empty;
  logic [RW-1:0]         head;

  // Credits use registered state only, so a pop
  // this cycle cannot combinationally raise in_ready.
  assign credits  = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign in_ready = (credits < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign s1_sum   = {1'b0, s1_a} + {1'b0, s1_b};

  // Stage 1: capture operands and tag on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  // Count pushed results with carry set, saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_count <= '0;
    end else if (s1_valid && s1_sum[DATA_WIDTH] &&
                 (carry_count != '1)) begin
      carry_count <= carry_count + 1'b1;
    end
  end

  add_core_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s1_valid),
    .push_data ({s1_tag, s1_sum}),
    .pop       (out_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_sum   = head[DATA_WIDTH-1:0];
  assign out_carry = head[DATA_WIDTH];
  assign out_tag   = head[RW-1:DATA_WIDTH+1];

endmodule

// File: tb/tb_add_core.sv
// Scoreboard bench for add_core: expected results
// queued on accept, compared as the DUT pops them.
module tb_add_core;
  import add_core_pkg_hdl::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sum;
  logic        out_carry;
  logic [3:0]  out_tag;
  logic [15:0] carry_count;

  add_core #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .TAG_WIDTH  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .out_tag     (out_tag),
    .carry_count (carry_count)
  );

  always #5 clock = ~clock;

  add_res_t exp_q[$];
  add_res_t got_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  // Sample handshakes mid-cycle, then move to the next negedge.
  task automatic step();
    add_res_t e;
    add_res_t g;
    #1;
    if (in_valid && in_ready) begin
      {e.carry, e.sum} = {1'b0, in_a} + {1'b0, in_b};
      e.tag = in_tag;
      exp_q.push_back(e);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      g.sum   = out_sum;
      g.carry = out_carry;
      g.tag   = out_tag;
      got_q.push_back(g);
    end
    @(negedge clock);
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (got_q.size() >= n) break;
      step();
    end
  endtask

  task automatic test_reset();
    n_chk++; if (in_ready !== 1'b1)
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++; if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (out_sum !== 8'h00)
      $display("FAIL rst_out_sum: got %h want 00", out_sum);
    else n_pass++;
    n_chk++; if (out_carry !== 1'b0)
      $display("FAIL rst_out_carry: got %b want 0", out_carry);
    else n_pass++;
    n_chk++; if (out_tag !== 4'h0)
      $display("FAIL rst_out_tag: got %h want 0", out_tag);
    else n_pass++;
    n_chk++; if (carry_count !== 16'h0)
      $display("FAIL rst_carry_count: got %h want 0", carry_count);
    else n_pass++;
  endtask

  task automatic test_single();
    add_res_t e;
    add_res_t g;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'h12; in_b = 8'h34; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0)
      $display("FAIL single_lat1: got %b want 0", out_valid);
    else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b1)
      $display("FAIL single_lat2: got %b want 1", out_valid);
    else n_pass++;
    n_chk++; if (out_sum !== 8'h46)
      $display("FAIL single_sum: got %h want 46", out_sum);
    else n_pass++;
    n_chk++; if (out_carry !== 1'b0)
      $display("FAIL single_carry: got %b want 0", out_carry);
    else n_pass++;
    n_chk++; if (out_tag !== 4'd3)
      $display("FAIL single_tag: got %h want 3", out_tag);
    else n_pass++;
    drain(1);
    n_chk++;
    if (got_q.size() != 1) begin
      $display("FAIL single_pop: got %0d want 1", got_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_chk++; if (g !== e)
        $display("FAIL single_sb: got %h want %h", g, e);
      else n_pass++;
    end
    n_chk++; if (out_valid !== 1'b0)
      $display("FAIL single_empty: got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_carry();
    add_res_t g;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'hFF; in_b = 8'h01; in_tag = 4'd5;
    step();
    drain(1);
    exp_q.delete();
    n_chk++;
    if (got_q.size() != 1) begin
      $display("FAIL carry_pop: got %0d want 1", got_q.size());
      got_q.delete();
    end else begin
      n_pass++;
      g = got_q.pop_front();
      n_chk++; if (g !== {4'd5, 1'b1, 8'h00})
        $display("FAIL carry_res: got %h want 0b00", g);
      else n_pass++;
    end
    n_chk++; if (carry_count !== 16'd1)
      $display("FAIL carry_count: got %h want 1", carry_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    add_res_t e;
    add_res_t g;
    int idx = 0;
    int a0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_a = 8'(idx * 17 + 40);
      in_b = 8'(idx * 50 + 100);
      in_tag = 4'(idx);
      a0 = n_acc;
      step();
      if (n_acc != a0) idx++;
    end
    n_chk++; if (idx != 4)
      $display("FAIL bp_accepts: got %0d want 4", idx);
    else n_pass++;
    n_chk++; if (in_ready !== 1'b0)
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      in_a = 8'(idx * 17 + 40);
      in_b = 8'(idx * 50 + 100);
      in_tag = 4'(idx);
      a0 = n_acc;
      step();
      if (n_acc != a0) idx++;
    end
    n_chk++; if (idx != 6)
      $display("FAIL bp_all_accepted: got %0d want 6", idx);
    else n_pass++;
    drain(6);
    n_chk++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      $display("FAIL bp_count: got %0d want 6", got_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        n_chk++; if (g.tag !== 4'(i))
          $display("FAIL bp_order: got %0d want %0d", g.tag, i);
        else n_pass++;
        n_chk++; if (g !== e)
          $display("FAIL bp_sb: got %h want %h", g, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stream();
    add_res_t e;
    add_res_t g;
    int idx = 0;
    int cyc = 0;
    int a0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (idx < 100 && cyc < 200) begin
      in_a   = 8'($urandom_range(0, 255));
      in_b   = 8'($urandom_range(0, 255));
      in_tag = 4'($urandom_range(0, 15));
      a0 = n_acc;
      step();
      cyc++;
      if (n_acc != a0) idx++;
    end
    in_valid = 1'b0;
    while (got_q.size() < 100 && cyc < 250) begin
      step();
      cyc++;
    end
    n_chk++; if (cyc != 102)
      $display("FAIL stream_rate: got %0d cycles want 102", cyc);
    else n_pass++;
    n_chk++;
    if (got_q.size() != 100 || exp_q.size() != 100) begin
      $display("FAIL stream_count: got %0d want 100", got_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      n_pass++;
      for (int i = 0; i < 100; i++) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        n_chk++; if (g !== e)
          $display("FAIL stream_sb[%0d]: got %h want %h", i, g, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'd7;
    step();
    in_a = 8'h01; in_b = 8'h02; in_tag = 4'd8;
    step();
    in_a = 8'h80; in_b = 8'h80; in_tag = 4'd9;
    step();
    in_valid = 1'b0;
    step();
    n_chk++; if (out_valid !== 1'b1)
      $display("FAIL mid_queued: got %b want 1", out_valid);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0)
      $display("FAIL mid_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (in_ready !== 1'b1)
      $display("FAIL mid_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++; if (carry_count !== 16'h0)
      $display("FAIL mid_carry_count: got %h want 0", carry_count);
    else n_pass++;
    n_chk++; if (out_sum !== 8'h00)
      $display("FAIL mid_out_sum: got %h want 00", out_sum);
    else n_pass++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_chk++; if (got_q.size() != 0)
      $display("FAIL mid_stale: got %0d results want 0", got_q.size());
    else n_pass++;
    n_chk++; if (out_valid !== 1'b0)
      $display("FAIL mid_after: got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int a0 = n_acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'hFF; in_b = 8'h01; in_tag = 4'd1;
    for (int c = 0; c < 70000; c++) begin
      if (n_acc - a0 >= 65534) break;
      step();
    end
    drain(0);
    for (int i = 0; i < 3; i++) step();
    n_chk++; if (carry_count !== 16'hFFFE)
      $display("FAIL sat_near: got %h want fffe", carry_count);
    else n_pass++;
    exp_q.delete();
    got_q.delete();
    a0 = n_acc;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (n_acc - a0 >= 5) break;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_chk++; if (carry_count !== 16'hFFFF)
      $display("FAIL sat_hold: got %h want ffff", carry_count);
    else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_single();
    test_carry();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
